sa_sequencer: RTL and testbench

SA_SEQUENCER -- requirements
Module: sa_sequencer

---
 rtl/sa_sequencer.sv | 132 +++++++++++++
 tb/tb_sa_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_sequencer.sv
// Systolic-array pass sequencer: IDLE -> FEED -> DRAIN -> CAPTURE -> CLEAR with skewed row/col valids.
// Optional abort port pair is enabled by defining SA_SEQ_ABORT_EN.
module sa_sequencer #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int K_W  = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [K_W-1:0]  k_len,
`ifdef SA_SEQ_ABORT_EN
    input  logic            abort,
    output logic            aborted,
`endif
    output logic            busy,
    output logic            done,
    output logic            feed_en,
    output logic [K_W-1:0]  feed_idx,
    output logic [ROWS-1:0] row_valid,
    output logic [COLS-1:0] col_valid,
    output logic            counter_sync,
    output logic            psum_capture
);

    localparam int SH_LEN     = (ROWS > COLS) ? ROWS : COLS;
    localparam int DR_W       = $clog2(ROWS + COLS);
    localparam int DRAIN_LAST = ROWS + COLS - 3;
    localparam logic [K_W-1:0]  K_ONE  = 1;
    localparam logic [DR_W-1:0] DR_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_CAPTURE,
        S_CLEAR
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [K_W-1:0]    r_k;
    logic [K_W-1:0]    r_feed_cnt;
    logic [DR_W-1:0]   r_drain_cnt;
    logic [SH_LEN-1:0] r_vsh;
    logic              w_abort;
    logic              w_feed_last;
    logic              w_drain_last;
    logic              w_feed_nxt;

`ifdef SA_SEQ_ABORT_EN
    logic r_aborted;
    assign w_abort = abort && ((r_state == S_FEED) || (r_state == S_DRAIN) || (r_state == S_CAPTURE));
`else
    assign w_abort = 1'b0;
`endif

    assign w_feed_last  = (r_feed_cnt == (r_k - K_ONE));
    assign w_drain_last = (r_drain_cnt == DR_W'(DRAIN_LAST));
    assign w_feed_nxt   = (w_state_nxt == S_FEED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (k_len != '0) ? S_FEED : S_CLEAR;
                end
            end
            S_FEED:    if (w_feed_last)  w_state_nxt = S_DRAIN;
            S_DRAIN:   if (w_drain_last) w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_CLEAR;
            S_CLEAR:   w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = S_CLEAR;
        end
    end

    // Stage 0 of the valid shift register loads the next-cycle feed enable,
    // so row_valid[0]/col_valid[0] coincide with feed_en and each later stage adds one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_k         <= '0;
            r_feed_cnt  <= '0;
            r_drain_cnt <= '0;
            r_vsh       <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_k <= k_len;
            end
            r_feed_cnt  <= ((r_state == S_FEED) && !w_feed_last && !w_abort) ? (r_feed_cnt + K_ONE) : '0;
            r_drain_cnt <= ((r_state == S_DRAIN) && !w_drain_last && !w_abort) ? (r_drain_cnt + DR_ONE) : '0;
            r_vsh       <= w_abort ? '0 : {r_vsh[SH_LEN-2:0], w_feed_nxt};
        end
    end

`ifdef SA_SEQ_ABORT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_abort;
        end
    end
`endif

    always_comb begin
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_CLEAR);
        feed_en      = (r_state == S_FEED);
        feed_idx     = (r_state == S_FEED) ? r_feed_cnt : '0;
        counter_sync = (r_state == S_FEED) || (r_state == S_DRAIN) || (r_state == S_CAPTURE);
        psum_capture = (r_state == S_CAPTURE) && !w_abort;
`ifdef SA_SEQ_ABORT_EN
        aborted      = (r_state == S_CLEAR) && r_aborted;
`endif
    end

    assign row_valid = r_vsh[ROWS-1:0];
    assign col_valid = r_vsh[COLS-1:0];

endmodule

// File: tb/tb_sa_sequencer.sv
// Scoreboard bench for sa_sequencer: stimulus queues expected events, a negedge monitor pops and compares.
// Define SA_SEQ_ABORT_EN to also exercise the abort port pair.
module tb_sa_sequencer;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int K_W  = 8;
    localparam int SH   = (ROWS > COLS) ? ROWS : COLS;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic [K_W-1:0]  k_len;
    logic            busy, done, feed_en, counter_sync, psum_capture;
    logic [K_W-1:0]  feed_idx;
    logic [ROWS-1:0] row_valid;
    logic [COLS-1:0] col_valid;
`ifdef SA_SEQ_ABORT_EN
    logic            abort;
    logic            aborted;
`endif

    sa_sequencer #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .k_len        (k_len),
`ifdef SA_SEQ_ABORT_EN
        .abort        (abort),
        .aborted      (aborted),
`endif
        .busy         (busy),
        .done         (done),
        .feed_en      (feed_en),
        .feed_idx     (feed_idx),
        .row_valid    (row_valid),
        .col_valid    (col_valid),
        .counter_sync (counter_sync),
        .psum_capture (psum_capture)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int a;
        int b;
    } ev_t;

    ev_t q_feed[$];
    ev_t q_vld[$];
    ev_t q_cap[$];
    ev_t q_done[$];
    ev_t q_busy[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic flush();
        q_feed.delete();
        q_vld.delete();
        q_cap.delete();
        q_done.delete();
        q_busy.delete();
    endtask

    task automatic chk_zero(input string pre);
        chk({pre, "_ctl"}, int'({busy, done, feed_en, counter_sync, psum_capture}), 0);
        chk({pre, "_idx"}, int'(feed_idx), 0);
        chk({pre, "_rv"}, int'(row_valid), 0);
        chk({pre, "_cv"}, int'(col_valid), 0);
    endtask

    // Expected events for a pass whose start is sampled at the end of cycle t; abort_at < 0 means no abort.
    task automatic expect_pass(input int t, input int k, input int abort_at);
        int  dcyc;
        bit  ab;
        ev_t e;
        dcyc = (k == 0) ? t + 1 : t + k + ROWS + COLS;
        ab   = 1'b0;
        if (k != 0 && abort_at >= t + 1 && abort_at <= dcyc - 1) begin
            ab   = 1'b1;
            dcyc = abort_at + 1;
        end
        for (int i = 0; i < k; i++) begin
            if (!ab || (t + 1 + i) <= abort_at) begin
                e = '{t + 1 + i, i, 0};
                q_feed.push_back(e);
            end
        end
        for (int c = t + 1; c <= t + k + SH - 1; c++) begin
            int rv = 0;
            int cv = 0;
            for (int r = 0; r < ROWS; r++)
                if (c >= t + 1 + r && c <= t + k + r) rv |= (1 << r);
            for (int q = 0; q < COLS; q++)
                if (c >= t + 1 + q && c <= t + k + q) cv |= (1 << q);
            if ((rv | cv) != 0 && (!ab || c <= abort_at)) begin
                e = '{c, rv, cv};
                q_vld.push_back(e);
            end
        end
        if (!ab && k != 0) begin
            e = '{dcyc - 1, 0, 0};
            q_cap.push_back(e);
        end
        e = '{dcyc, int'(ab), 0};
        q_done.push_back(e);
        for (int c = t + 1; c <= dcyc; c++) begin
            e = '{c, (c != dcyc) ? 1 : 0, 0};
            q_busy.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        int  ab_act;
        if (reset_n) begin
            if (feed_en) begin
                if (q_feed.size() == 0) chk("feed_unexpected", 1, 0);
                else begin
                    e = q_feed.pop_front();
                    chk("feed_cycle", cyc, e.cyc);
                    chk("feed_idx", int'(feed_idx), e.a);
                end
            end else if (feed_idx != '0) begin
                chk("feed_idx_outside_feed", int'(feed_idx), 0);
            end
            if (row_valid != '0 || col_valid != '0) begin
                if (q_vld.size() == 0) chk("valid_unexpected", int'(row_valid), 0);
                else begin
                    e = q_vld.pop_front();
                    chk("valid_cycle", cyc, e.cyc);
                    chk("row_valid", int'(row_valid), e.a);
                    chk("col_valid", int'(col_valid), e.b);
                end
            end
            if (psum_capture) begin
                if (q_cap.size() == 0) chk("capture_unexpected", 1, 0);
                else begin
                    e = q_cap.pop_front();
                    chk("capture_cycle", cyc, e.cyc);
                end
            end
`ifdef SA_SEQ_ABORT_EN
            ab_act = int'(aborted);
            if (aborted && !done) chk("aborted_without_done", 1, 0);
`else
            ab_act = 0;
`endif
            if (done) begin
                if (q_done.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    e = q_done.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_aborted", ab_act, e.a);
                end
            end
            if (busy) begin
                if (q_busy.size() == 0) chk("busy_unexpected", 1, 0);
                else begin
                    e = q_busy.pop_front();
                    chk("busy_cycle", cyc, e.cyc);
                    chk("counter_sync", int'(counter_sync), e.a);
                end
            end else if (counter_sync) begin
                chk("counter_sync_idle", 1, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset_n = 1'b0;
        start   = 1'b0;
        k_len   = '0;
`ifdef SA_SEQ_ABORT_EN
        abort   = 1'b0;
`endif
        #2;
        chk_zero("reset_t0");
        tick();
        tick();
        chk_zero("reset_held");
        reset_n = 1'b1;
        tick();
        tick();
        chk_zero("idle_after_reset");

        // Basic pass K=3 with hand-computed timing points.
        t = cyc;
        start = 1'b1;
        k_len = 8'd3;
        expect_pass(t, 3, -1);
        tick();
        start = 1'b0;
        wait_to(t + 3);
        chk("rv3_before", int'(row_valid[3]), 0);
        wait_to(t + 4);
        chk("rv3_first", int'(row_valid[3]), 1);
        wait_to(t + 6);
        chk("rv3_last", int'(row_valid[3]), 1);
        wait_to(t + 7);
        chk("rv3_after", int'(row_valid[3]), 0);
        wait_to(t + 10);
        chk("capture_t10", int'(psum_capture), 1);
        wait_to(t + 11);
        chk("done_t11", int'(done), 1);
        wait_to(t + 14);

        // Start held high across a whole pass: next pass sampled once IDLE returns.
        t = cyc;
        start = 1'b1;
        k_len = 8'd3;
        expect_pass(t, 3, -1);
        expect_pass(t + 12, 3, -1);
        wait_to(t + 12);
        chk("held_idle_t12", int'(busy), 0);
        wait_to(t + 13);
        start = 1'b0;
        chk("held_feed_t13", int'(feed_en), 1);
        wait_to(t + 28);

        // Zero-depth pass.
        t = cyc;
        start = 1'b1;
        k_len = 8'd0;
        expect_pass(t, 0, -1);
        tick();
        start = 1'b0;
        chk("k0_done_t1", int'(done), 1);
        wait_to(t + 5);

        // Asynchronous reset mid-pass, then a normal pass right after release.
        t = cyc;
        start = 1'b1;
        k_len = 8'd3;
        expect_pass(t, 3, -1);
        tick();
        start = 1'b0;
        wait_to(t + 5);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("async_reset");
        flush();
        tick();
        tick();
        reset_n = 1'b1;
        t = cyc;
        start = 1'b1;
        k_len = 8'd2;
        expect_pass(t, 2, -1);
        tick();
        start = 1'b0;
        chk("post_reset_feed", int'(feed_en), 1);
        wait_to(t + 14);

        // Maximum depth: feed_idx runs to 254, capture at t+262.
        t = cyc;
        start = 1'b1;
        k_len = 8'd255;
        expect_pass(t, 255, -1);
        tick();
        start = 1'b0;
        wait_to(t + 255);
        chk("k255_last_idx", int'(feed_idx), 254);
        wait_to(t + 262);
        chk("k255_capture", int'(psum_capture), 1);
        wait_to(t + 266);

`ifdef SA_SEQ_ABORT_EN
        // Abort during DRAIN.
        t = cyc;
        start = 1'b1;
        k_len = 8'd3;
        expect_pass(t, 3, t + 5);
        tick();
        start = 1'b0;
        wait_to(t + 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valids_off", int'(row_valid), 0);
        chk("abort_done_aborted", int'({done, aborted}), 3);
        wait_to(t + 14);

        // Abort in CAPTURE suppresses the strobe.
        t = cyc;
        start = 1'b1;
        k_len = 8'd2;
        expect_pass(t, 2, t + 9);
        tick();
        start = 1'b0;
        wait_to(t + 9);
        abort = 1'b1;
        #1;
        chk("abort_cap_suppressed", int'(psum_capture), 0);
        tick();
        abort = 1'b0;
        wait_to(t + 14);

        // Abort while IDLE has no effect.
        abort = 1'b1;
        tick();
        tick();
        abort = 1'b0;
        chk("abort_idle", int'(busy), 0);
        tick();
`endif

        tick();
        tick();
        chk("left_feed", q_feed.size(), 0);
        chk("left_valid", q_vld.size(), 0);
        chk("left_capture", q_cap.size(), 0);
        chk("left_done", q_done.size(), 0);
        chk("left_busy", q_busy.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
